uart_mem_loader: RTL and testbench

//  Parametrised UART-to-memory program loader. Assembles rx bytes into words, buffers them,
//  and writes them to sequential memory addresses via a valid/ready handshake.

---
 rtl/little_computer_pkg.sv | 13 +
 rtl/uart_mem_loader_if.sv | 17 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_mem_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/little_computer_pkg.sv
// Shared types and default widths for the little computer blocks.
package little_computer_pkg;
  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } loader_state_t;
endpackage

// File: rtl/uart_mem_loader_if.sv
// Memory write port of the loader.
// Handshake: a word transfers on a clk edge where mem_write_en and mem_ready are both high;
// mem_addr/mem_data stay stable while mem_write_en is high and not yet accepted.
interface uart_mem_loader_if
  import little_computer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) ();
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_data;
  logic                  mem_ready;

  modport master (output mem_write_en, mem_addr, mem_data, input mem_ready);
  modport slave  (input mem_write_en, mem_addr, mem_data, output mem_ready);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/uart_mem_loader.sv
// Assembles UART bytes into words, buffers them and writes them to consecutive memory addresses.
module uart_mem_loader
  import little_computer_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter bit HEADER_EN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  uart_mem_loader_if.master     mem,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic [WORD_WIDTH-1:0] checksum,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output loader_state_t         dbg_state
);
  localparam int BPW   = WORD_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  loader_state_t         state_q, state_d;
  logic                  load_en_q;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d, asm_next;
  logic [WORD_WIDTH-1:0] remaining_q, remaining_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] word_count_q, word_count_d;
  logic [WORD_WIDTH-1:0] checksum_q, checksum_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_rdata;
  logic                  start, accept, last_byte;

  assign start     = load_en && !load_en_q;
  assign accept    = wr_valid_q && mem.mem_ready;
  assign last_byte = (byte_idx_q == IDX_W'(BPW - 1));
  // Shifting in from the bottom leaves the first byte in the MSBs; from the top, in the LSBs.
  assign asm_next  = BIG_ENDIAN ? ((asm_q << 8) | WORD_WIDTH'(rx_byte))
                                : ((asm_q >> 8) | (WORD_WIDTH'(rx_byte) << (WORD_WIDTH - 8)));

  sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(asm_next),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    remaining_d  = remaining_q;
    wr_valid_d   = wr_valid_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    overflow_d   = overflow_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    fifo_pop     = !fifo_empty && (!wr_valid_q || accept) && !start;

    if (accept) begin
      wr_valid_d   = 1'b0;
      wr_addr_d    = wr_addr_q + ADDR_WIDTH'(1);
      word_count_d = word_count_q + ADDR_WIDTH'(1);
      checksum_d   = checksum_q + wr_data_q;
    end
    if (fifo_pop) begin
      wr_valid_d = 1'b1;
      wr_data_d  = fifo_rdata;
    end

    unique case (state_q)
      ST_HEADER: begin
        if (rx_valid) begin
          asm_d      = asm_next;
          byte_idx_d = last_byte ? '0 : byte_idx_q + IDX_W'(1);
          if (last_byte) begin
            remaining_d = asm_next;
            state_d     = (asm_next == '0) ? ST_DONE : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (!HEADER_EN && !load_en) begin
          state_d    = ST_DRAIN;
          byte_idx_d = '0;
        end else if (rx_valid) begin
          asm_d      = asm_next;
          byte_idx_d = last_byte ? '0 : byte_idx_q + IDX_W'(1);
          if (last_byte) begin
            fifo_push = 1'b1;
            // A dropped word still counts toward the header length.
            if (fifo_full && !fifo_pop) overflow_d = 1'b1;
            if (HEADER_EN) begin
              remaining_d = remaining_q - WORD_WIDTH'(1);
              if (remaining_q == WORD_WIDTH'(1)) state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !wr_valid_q) state_d = ST_DONE;
      end
      default: ;
    endcase

    if (start) begin
      state_d      = HEADER_EN ? ST_HEADER : ST_LOAD;
      fifo_push    = 1'b0;
      fifo_flush   = 1'b1;
      byte_idx_d   = '0;
      asm_d        = '0;
      remaining_d  = '0;
      wr_valid_d   = 1'b0;
      wr_addr_d    = base_addr;
      word_count_d = '0;
      checksum_d   = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      load_en_q    <= 1'b0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      remaining_q  <= '0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_en_q    <= load_en;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      remaining_q  <= remaining_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem.mem_write_en = wr_valid_q;
  assign mem.mem_addr     = wr_addr_q;
  assign mem.mem_data     = wr_data_q;
  assign word_count       = word_count_q;
  assign checksum         = checksum_q;
  assign overflow         = overflow_q;
  assign busy             = (state_q == ST_HEADER) || (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done             = (state_q == ST_DONE);
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: three configurations share the byte stream and mem_ready.
module tb_uart_mem_loader;
  import little_computer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en_a, load_en_b, load_en_c;
  logic [24:0] base_a, base_c;
  logic [3:0]  base_b;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        mem_ready;

  logic [24:0] wc_a, wc_c;
  logic [3:0]  wc_b;
  logic [15:0] cs_a, cs_b, cs_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
  loader_state_t st_a, st_b, st_c;

  logic [40:0] exp_a_q[$];
  logic [19:0] exp_b_q[$];
  logic [40:0] exp_c_q[$];
  logic [40:0] mon_a_e, mon_c_e;
  logic [19:0] mon_b_e;

  int checks = 0;
  int errors = 0;

  uart_mem_loader_if #(.ADDR_WIDTH(25), .WORD_WIDTH(16)) mem_a ();
  uart_mem_loader_if #(.ADDR_WIDTH(4),  .WORD_WIDTH(16)) mem_b ();
  uart_mem_loader_if #(.ADDR_WIDTH(25), .WORD_WIDTH(16)) mem_c ();
  assign mem_a.mem_ready = mem_ready;
  assign mem_b.mem_ready = mem_ready;
  assign mem_c.mem_ready = mem_ready;

  uart_mem_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(25), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b1), .HEADER_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .load_en(load_en_a), .base_addr(base_a), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .mem(mem_a), .word_count(wc_a), .checksum(cs_a), .busy(busy_a),
    .done(done_a), .overflow(ovf_a), .dbg_state(st_a));

  uart_mem_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(4), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b0), .HEADER_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load_en(load_en_b), .base_addr(base_b), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .mem(mem_b), .word_count(wc_b), .checksum(cs_b), .busy(busy_b),
    .done(done_b), .overflow(ovf_b), .dbg_state(st_b));

  uart_mem_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(25), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b1), .HEADER_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .load_en(load_en_c), .base_addr(base_c), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .mem(mem_c), .word_count(wc_c), .checksum(cs_c), .busy(busy_c),
    .done(done_c), .overflow(ovf_c), .dbg_state(st_c));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input string tag, input int which, input int budget);
    int n = 0;
    while (!done_of(which) && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(done_of(which)), 64'd1);
  endtask

  // ---------------- scoreboards: one accepted write per cycle ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_a.mem_write_en && mem_ready) begin
      if (exp_a_q.size() == 0) check("a_unexpected_write", 64'(exp_a_q.size()), 64'd1);
      else begin
        mon_a_e = exp_a_q.pop_front();
        check("a_write", 64'({mem_a.mem_addr, mem_a.mem_data}), 64'(mon_a_e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && mem_b.mem_write_en && mem_ready) begin
      if (exp_b_q.size() == 0) check("b_unexpected_write", 64'(exp_b_q.size()), 64'd1);
      else begin
        mon_b_e = exp_b_q.pop_front();
        check("b_write", 64'({mem_b.mem_addr, mem_b.mem_data}), 64'(mon_b_e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && mem_c.mem_write_en && mem_ready) begin
      if (exp_c_q.size() == 0) check("c_unexpected_write", 64'(exp_c_q.size()), 64'd1);
      else begin
        mon_c_e = exp_c_q.pop_front();
        check("c_write", 64'({mem_c.mem_addr, mem_c.mem_data}), 64'(mon_c_e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    load_en_a = 1'b0; load_en_b = 1'b0; load_en_c = 1'b0;
    base_a = '0; base_b = '0; base_c = '0;
    rx_byte = '0; rx_valid = 1'b0; mem_ready = 1'b0;
    tick(2);
    check("rst_a_write_en", 64'(mem_a.mem_write_en), 64'd0);
    rst = 1'b0;
    tick(1);
    check("rst_a_state", 64'(st_a), 64'(ST_IDLE));
    check("rst_a_outs", 64'({wc_a, cs_a, busy_a, done_a, ovf_a}), 64'd0);
    check("rst_a_addr_data", 64'({mem_a.mem_addr, mem_a.mem_data}), 64'd0);
    check("rst_b_outs", 64'({wc_b, cs_b, busy_b, done_b, ovf_b, mem_b.mem_write_en}), 64'd0);
    check("rst_c_outs", 64'({wc_c, cs_c, busy_c, done_c, ovf_c, mem_c.mem_write_en}), 64'd0);

    // Big-endian basic load ended by load_en fall
    exp_a_q.push_back({25'h100, 16'h1234});
    exp_a_q.push_back({25'h101, 16'h5678});
    mem_ready = 1'b1;
    base_a    = 25'h100;
    load_en_a = 1'b1;
    tick(1);
    check("a_busy_load", 64'(busy_a), 64'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    check("a_latency_1", 64'(mem_a.mem_write_en), 64'd0);
    tick(1);
    check("a_latency_2", 64'(mem_a.mem_write_en), 64'd1);
    send_byte(8'h56);
    send_byte(8'h78);
    tick(2);
    load_en_a = 1'b0;
    wait_done("a_basic_done", 0, 50);
    check("a_basic_count", 64'(wc_a), 64'd2);
    check("a_basic_sum", 64'(cs_a), 64'h68AC);
    check("a_basic_busy", 64'(busy_a), 64'd0);
    check("a_basic_queue", 64'(exp_a_q.size()), 64'd0);

    // Memory stall: 6 words, 4 FIFO + write register hold 5, the 6th is dropped
    mem_ready = 1'b0;
    base_a    = 25'h200;
    for (int i = 1; i <= 5; i++) exp_a_q.push_back({25'h200 + 25'(i - 1), 16'hA000 + 16'(i)});
    load_en_a = 1'b1;
    tick(1);
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'hA0);
      send_byte(8'(i));
    end
    tick(1);
    check("a_stall_ovf", 64'(ovf_a), 64'd1);
    check("a_stall_wen", 64'(mem_a.mem_write_en), 64'd1);
    check("a_stall_hold1", 64'({mem_a.mem_addr, mem_a.mem_data}), 64'({25'h200, 16'hA001}));
    tick(5);
    check("a_stall_hold2", 64'({mem_a.mem_addr, mem_a.mem_data}), 64'({25'h200, 16'hA001}));
    check("a_stall_count0", 64'(wc_a), 64'd0);
    mem_ready = 1'b1;
    load_en_a = 1'b0;
    wait_done("a_stall_done", 0, 50);
    check("a_stall_count", 64'(wc_a), 64'd5);
    check("a_stall_sum", 64'(cs_a), 64'h200F);
    check("a_stall_queue", 64'(exp_a_q.size()), 64'd0);

    // Abort: restart while data is buffered and a write is pending
    mem_ready = 1'b0;
    base_a    = 25'h300;
    load_en_a = 1'b1;
    tick(1);
    send_byte(8'hC0); send_byte(8'h01);
    send_byte(8'hC0); send_byte(8'h02);
    tick(1);
    load_en_a = 1'b0;
    tick(1);
    base_a    = 25'h400;
    load_en_a = 1'b1;
    tick(1);
    check("a_abort_wen", 64'(mem_a.mem_write_en), 64'd0);
    check("a_abort_count", 64'(wc_a), 64'd0);
    check("a_abort_state", 64'(st_a), 64'(ST_LOAD));
    exp_a_q.push_back({25'h400, 16'hBEEF});
    mem_ready = 1'b1;
    tick(3);
    send_byte(8'hBE); send_byte(8'hEF);
    tick(2);
    load_en_a = 1'b0;
    wait_done("a_abort_done", 0, 50);
    check("a_abort_final_count", 64'(wc_a), 64'd1);
    check("a_abort_sum", 64'(cs_a), 64'hBEEF);

    // Little-endian, 4-bit address wrap
    exp_b_q.push_back({4'hE, 16'h3412});
    exp_b_q.push_back({4'hF, 16'h7856});
    exp_b_q.push_back({4'h0, 16'hBC9A});
    base_b    = 4'hE;
    load_en_b = 1'b1;
    tick(1);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h9A); send_byte(8'hBC);
    tick(2);
    load_en_b = 1'b0;
    wait_done("b_wrap_done", 1, 50);
    check("b_wrap_count", 64'(wc_b), 64'd3);
    check("b_wrap_sum", 64'(cs_b), 64'h6902);

    // Partial word discarded on load_en fall
    exp_b_q.push_back({4'h5, 16'h2211});
    base_b    = 4'h5;
    load_en_b = 1'b1;
    tick(1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    load_en_b = 1'b0;
    wait_done("b_partial_done", 1, 50);
    tick(3);
    check("b_partial_count", 64'(wc_b), 64'd1);
    check("b_partial_sum", 64'(cs_b), 64'h2211);
    check("b_partial_queue", 64'(exp_b_q.size()), 64'd0);

    // Header length 3: self-terminating with load_en held high
    exp_c_q.push_back({25'h40, 16'h1111});
    exp_c_q.push_back({25'h41, 16'h2222});
    exp_c_q.push_back({25'h42, 16'h3333});
    base_c    = 25'h40;
    load_en_c = 1'b1;
    tick(1);
    check("c_header_state", 64'(st_c), 64'(ST_HEADER));
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h33);
    wait_done("c_len3_done", 2, 50);
    check("c_len3_count", 64'(wc_c), 64'd3);
    check("c_len3_sum", 64'(cs_c), 64'h6666);
    check("c_len3_queue", 64'(exp_c_q.size()), 64'd0);

    // Header length 0: straight to done, nothing written
    load_en_c = 1'b0;
    tick(1);
    load_en_c = 1'b1;
    tick(1);
    check("c_len0_busy", 64'(busy_c), 64'd1);
    send_byte(8'h00); send_byte(8'h00);
    check("c_len0_done", 64'(done_c), 64'd1);
    tick(4);
    check("c_len0_count", 64'(wc_c), 64'd0);
    check("c_len0_wen", 64'(mem_c.mem_write_en), 64'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
